// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: drain FSM states and
// core access-type encodings.
package store_buffer_pkg;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_WRITE = 1'b1
  } sb_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Count register needs one bit more than a pointer to represent "full".
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Entry storage for the store buffer: circular FIFO with head/tail/count,
// push/pop/in-place merge, and a youngest-match associative lookup.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              merge_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] lkp_addr_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o,
  output logic              tail_hit_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, youngest;
  logic [CNT_W-1:0]  count_q, count_d;

  assign youngest = tail_q - PTR_W'(1);

  always_comb begin
    head_d  = pop_i  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push_i ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage has no reset; validity comes solely from head/count,
  // so stale contents are never observed and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= wr_addr_i;
      data_q[tail_q] <= wr_data_i;
    end else if (merge_i) begin
      data_q[youngest] <= wr_data_i;
    end
  end

  // NOTE: every output of this always_comb is assigned a default first, so no
  // path through the loop can leave a value held (which would infer a latch).
  // Scan oldest to youngest; the last match wins, giving the youngest entry.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (addr_q[head_q + PTR_W'(k)] == lkp_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[head_q + PTR_W'(k)];
      end
    end
  end

  assign tail_hit_o  = (count_q != '0) && (addr_q[youngest] == wr_addr_i);
  assign count_o     = count_q;
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core MEM-stage port and a handshaked write port.
// Build option: define STORE_BUFFER_COALESCE_EN to merge same-address stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_full,
  output logic              bus_wreq,
  output logic [ADDR_W-1:0] bus_waddr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_wack,
  output logic [ADDR_W-1:0] bus_raddr,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err_ovf
);

  localparam int CNT_W = cnt_width(DEPTH);
`ifdef STORE_BUFFER_COALESCE_EN
  localparam bit COALESCE_EN = 1'b1;
`else
  localparam bit COALESCE_EN = 1'b0;
`endif

  sb_state_e         state_q;
  logic              bus_wreq_q, err_ovf_q, err_ovf_d;
  logic [CNT_W-1:0]  count;
  logic              store_req, load_req, merge, push, pop, more;
  logic              fwd_hit, tail_hit;
  logic [DATA_W-1:0] fwd_data;

  assign store_req = core_req && (core_rw == MEM_WRITE);
  assign load_req  = core_req && (core_rw == MEM_READ);
  assign core_full = (count == CNT_W'(DEPTH));

  // The head must not change under an outstanding write request.
  assign merge = COALESCE_EN && store_req && tail_hit &&
                 !((state_q == SB_WRITE) && (count == CNT_W'(1)));
  assign push  = store_req && !merge && !core_full;
  assign pop   = (state_q == SB_WRITE) && bus_wack;
  assign more  = (count > CNT_W'(1)) || push;

  assign err_ovf_d = err_ovf_q || (store_req && !merge && core_full);

  sb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .merge_i     (merge),
    .wr_addr_i   (core_addr),
    .wr_data_i   (core_wdata),
    .lkp_addr_i  (core_addr),
    .count_o     (count),
    .head_addr_o (bus_waddr),
    .head_data_o (bus_wdata),
    .hit_o       (fwd_hit),
    .hit_data_o  (fwd_data),
    .tail_hit_o  (tail_hit)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SB_IDLE;
      bus_wreq_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      case (state_q)
        SB_IDLE: begin
          if (count != '0) begin
            state_q    <= SB_WRITE;
            bus_wreq_q <= 1'b1;
          end
        end
        SB_WRITE: begin
          if (bus_wack && !more) begin
            state_q    <= SB_IDLE;
            bus_wreq_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= SB_IDLE;
          bus_wreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_wreq   = bus_wreq_q;
  assign err_ovf    = err_ovf_q;
  assign bus_raddr  = core_addr;
  assign core_rdata = (load_req && fwd_hit) ? fwd_data : bus_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4); expectations
// follow STORE_BUFFER_COALESCE_EN when it is defined.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst, core_req, core_rw, core_full, bus_wreq, bus_wack, err_ovf;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [31:0] bus_waddr, bus_wdata, bus_raddr, bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_rw    (core_rw),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_full  (core_full),
    .bus_wreq   (bus_wreq),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .bus_wack   (bus_wack),
    .bus_raddr  (bus_raddr),
    .bus_rdata  (bus_rdata),
    .err_ovf    (err_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    core_req   = 1'b1;
    core_rw    = 1'b1;
    core_addr  = a;
    core_wdata = d;
    tick();
    core_req   = 1'b0;
    core_rw    = 1'b0;
  endtask

  task automatic expect_drain(input string tag, input logic [31:0] a, input logic [31:0] d);
    int w = 0;
    while (!bus_wreq && w < 8) begin
      tick();
      w++;
    end
    check({tag, "_wreq"}, bus_wreq, 1);
    check({tag, "_waddr"}, bus_waddr, a);
    check({tag, "_wdata"}, bus_wdata, d);
    bus_wack = 1'b1;
    tick();
    bus_wack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; core_rw = 1'b0; core_addr = '0;
    core_wdata = '0; bus_wack = 1'b0; bus_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_wreq", bus_wreq, 0);
    check("rst_full", core_full, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_count", dut.count, 0);

    // 1: single store, ack two cycles after the request rises
    store(32'h100, 32'hDEADBEEF);
    check("t1_wreq_lat", bus_wreq, 0);
    tick();
    check("t1_wreq", bus_wreq, 1);
    check("t1_waddr", bus_waddr, 32'h100);
    check("t1_wdata", bus_wdata, 32'hDEADBEEF);
    tick();
    check("t1_waddr_hold", bus_waddr, 32'h100);
    check("t1_wdata_hold", bus_wdata, 32'hDEADBEEF);
    bus_wack = 1'b1;
    tick();
    bus_wack = 1'b0;
    check("t1_wreq_done", bus_wreq, 0);
    check("t1_count_done", dut.count, 0);

    // 2: fill, overflow, back-to-back drain in program order
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hA0 + 32'(i));
    check("t2_full", core_full, 1);
    check("t2_count", dut.count, 4);
    core_req = 1'b1; core_rw = 1'b1; core_addr = 32'h10; core_wdata = 32'hBAD;
    #1;
    check("t2_full_5th", core_full, 1);
    tick();
    core_req = 1'b0; core_rw = 1'b0;
    check("t2_ovf", err_ovf, 1);
    check("t2_count_ovf", dut.count, 4);
    bus_wack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_wreq", bus_wreq, 1);
      check("t2_waddr", bus_waddr, 32'(4 * i));
      check("t2_wdata", bus_wdata, 32'hA0 + 32'(i));
      tick();
    end
    bus_wack = 1'b0;
    check("t2_wreq_done", bus_wreq, 0);
    check("t2_count_done", dut.count, 0);
    check("t2_ovf_sticky", err_ovf, 1);

    // 3: forwarding returns the youngest match, else backing memory
    store(32'h20, 32'd1);
    store(32'h20, 32'd2);
`ifdef STORE_BUFFER_COALESCE_EN
    check("t3_count", dut.count, 1);
`else
    check("t3_count", dut.count, 2);
`endif
    bus_rdata = 32'h55;
    core_req = 1'b1; core_rw = 1'b0; core_addr = 32'h20;
    #1;
    check("t3_fwd_hit", core_rdata, 32'd2);
    check("t3_raddr", bus_raddr, 32'h20);
    core_addr = 32'h24;
    #1;
    check("t3_fwd_miss", core_rdata, 32'h55);
    core_req = 1'b0; core_addr = 32'h20;
    #1;
    check("t3_noreq", core_rdata, 32'h55);
`ifndef STORE_BUFFER_COALESCE_EN
    expect_drain("t3_d0", 32'h20, 32'd1);
`endif
    expect_drain("t3_d1", 32'h20, 32'd2);
    check("t3_count_done", dut.count, 0);

    // 4: push and pop in the same cycle, tail wraps past index 3
    store(32'h30, 32'h300);
    store(32'h34, 32'h340);
    check("t4_count", dut.count, 2);
    check("t4_waddr", bus_waddr, 32'h30);
    core_req = 1'b1; core_rw = 1'b1; core_addr = 32'h38; core_wdata = 32'h380;
    bus_wack = 1'b1;
    tick();
    core_req = 1'b0; core_rw = 1'b0; bus_wack = 1'b0;
    check("t4_count_pp", dut.count, 2);
    expect_drain("t4_d0", 32'h34, 32'h340);
    expect_drain("t4_d1", 32'h38, 32'h380);
    check("t4_wreq_done", bus_wreq, 0);

    // 5: reset mid-drain, with an ack in the reset cycle
    store(32'h50, 32'h5);
    store(32'h54, 32'h6);
    store(32'h58, 32'h7);
    check("t5_count", dut.count, 3);
    check("t5_wreq", bus_wreq, 1);
    check("t5_ovf_pre", err_ovf, 1);
    rst = 1'b1; bus_wack = 1'b1;
    tick();
    rst = 1'b0; bus_wack = 1'b0;
    check("t5_wreq", bus_wreq, 0);
    check("t5_count_rst", dut.count, 0);
    check("t5_ovf_rst", err_ovf, 0);
    bus_rdata = 32'h77;
    core_req = 1'b1; core_rw = 1'b0; core_addr = 32'h50;
    #1;
    check("t5_read", core_rdata, 32'h77);
    core_req = 1'b0;
    tick();
    check("t5_wreq_stays", bus_wreq, 0);

    // 6: coalescing of same-address stores behind a draining head
    store(32'h3C, 32'd5);
    store(32'h40, 32'd7);
    store(32'h40, 32'd9);
`ifdef STORE_BUFFER_COALESCE_EN
    check("t6_count", dut.count, 2);
    expect_drain("t6_d0", 32'h3C, 32'd5);
    check("t6_count1", dut.count, 1);
    store(32'h40, 32'd11);
    check("t6_count_head", dut.count, 2);
    expect_drain("t6_d1", 32'h40, 32'd9);
    expect_drain("t6_d2", 32'h40, 32'd11);
`else
    check("t6_count", dut.count, 3);
    expect_drain("t6_d0", 32'h3C, 32'd5);
    expect_drain("t6_d1", 32'h40, 32'd7);
    expect_drain("t6_d2", 32'h40, 32'd9);
`endif
    check("t6_count_done", dut.count, 0);

    // 7: same-address store while full
    for (int i = 0; i < 4; i++) store(32'h60 + 32'(4 * i), 32'hC0 + 32'(i));
    store(32'h6C, 32'hEE);
    check("t7_count", dut.count, 4);
`ifdef STORE_BUFFER_COALESCE_EN
    check("t7_ovf", err_ovf, 0);
`else
    check("t7_ovf", err_ovf, 1);
`endif
    for (int i = 0; i < 3; i++) expect_drain("t7_d", 32'h60 + 32'(4 * i), 32'hC0 + 32'(i));
`ifdef STORE_BUFFER_COALESCE_EN
    expect_drain("t7_d3", 32'h6C, 32'hEE);
`else
    expect_drain("t7_d3", 32'h6C, 32'hC3);
`endif
    check("t7_wreq_done", bus_wreq, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
